ifu_fetch: RTL and testbench

//   Instruction fetch stage: owns the fetch PC and issues word requests to instruction memory.

---
 rtl/ifu_fetch_pkg.sv | 14 +
 rtl/ifu_fetch_obuf.sv | 40 ++++
 rtl/ifu_fetch.sv | 123 ++++++++++++
 tb/tb_ifu_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INSTR_W      = 32;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_obuf.sv
// One-entry valid/ready holding register for {pc, instr} between fetch and decode.
module ifu_fetch_obuf
    import ifu_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [XLEN-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Payload only moves on a load, so it stays put while stalled.
            if (load && !flush) begin
                out_pc    <= load_pc;
                out_instr <= load_instr;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the fetch PC, issues one word request at a time, handles redirects.
//   state   | meaning
//   S_REQ   | request (or hold a pending request) at the current address
//   S_WAIT  | one good request outstanding, response will be buffered
//   S_DRAIN | one stale request outstanding, response will be dropped
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr_q;
    logic            stale;
    logic            req_pending;
    logic            req_fire;
    logic            rsp_load;
    logic            obuf_valid;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_load = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_next = (stale || redirect_valid) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                end else if (redirect_valid) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // A pending request keeps its original address even after a redirect moves pc.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = req_pending ? req_addr_q : pc;
        if (!rst && (state == S_REQ)) begin
            imem_req_valid = req_pending || !obuf_valid || if_ready;
        end
        if_valid = obuf_valid && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_addr_q  <= RESET_PC;
            stale       <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            req_pending <= imem_req_valid && !imem_req_ready;
            if (imem_req_valid) begin
                req_addr_q <= imem_req_addr;
            end
            if (req_fire) begin
                stale <= 1'b0;
            end else if (redirect_valid && imem_req_valid) begin
                stale <= 1'b1;
            end
            if (redirect_valid) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (rsp_load) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    ifu_fetch_obuf #(
        .XLEN (XLEN)
    ) u_obuf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (rsp_load),
        .load_pc    (pc),
        .load_instr (imem_rsp_data),
        .out_ready  (if_ready),
        .out_valid  (obuf_valid),
        .out_pc     (if_pc),
        .out_instr  (if_instr)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: two instances (RESET_PC 0 and 0xFFFFFFFC), driven one at a time.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        redir_v  [2];
    logic [31:0] redir_pc [2];
    logic        req_rdy  [2];
    logic        rsp_v    [2];
    logic [31:0] rsp_d    [2];
    logic        if_rdy   [2];
    logic        req_v    [2];
    logic [31:0] req_a    [2];
    logic        ifv      [2];
    logic [31:0] ifpc     [2];
    logic [31:0] ifin     [2];

    int n_cmp = 0;
    int n_err = 0;
    logic [64:0] exp_if  [$];
    logic [32:0] exp_req [$];

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst[0]), .redirect_valid(redir_v[0]), .redirect_pc(redir_pc[0]),
        .imem_req_valid(req_v[0]), .imem_req_ready(req_rdy[0]), .imem_req_addr(req_a[0]),
        .imem_rsp_valid(rsp_v[0]), .imem_rsp_data(rsp_d[0]),
        .if_valid(ifv[0]), .if_ready(if_rdy[0]), .if_pc(ifpc[0]), .if_instr(ifin[0])
    );

    ifu_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .rst(rst[1]), .redirect_valid(redir_v[1]), .redirect_pc(redir_pc[1]),
        .imem_req_valid(req_v[1]), .imem_req_ready(req_rdy[1]), .imem_req_addr(req_a[1]),
        .imem_rsp_valid(rsp_v[1]), .imem_rsp_data(rsp_d[1]),
        .if_valid(ifv[1]), .if_ready(if_rdy[1]), .if_pc(ifpc[1]), .if_instr(ifin[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs just after the edge; checks follow at posedge+2.
    task automatic cyc(input int k, input logic rs, input logic rr, input logic ir,
                       input logic rv, input logic [31:0] rd,
                       input logic dv, input logic [31:0] dp);
        @(posedge clk);
        #1;
        rst[k]      = rs;
        req_rdy[k]  = rr;
        if_rdy[k]   = ir;
        rsp_v[k]    = rv;
        rsp_d[k]    = rd;
        redir_v[k]  = dv;
        redir_pc[k] = dp;
        #1;
    endtask

    task automatic push_if(input int k, input logic [31:0] pc, input logic [31:0] instr);
        exp_if.push_back({k[0], pc, instr});
    endtask

    task automatic push_req(input int k, input logic [31:0] addr);
        exp_req.push_back({k[0], addr});
    endtask

    // Monitor: pops on every accepted request and every non-flushed decode handshake.
    always @(negedge clk) begin : mon
        logic [64:0] ef;
        logic [32:0] er;
        for (int k = 0; k < 2; k++) begin
            if (ifv[k] && if_rdy[k] && !redir_v[k] && !rst[k]) begin
                if (exp_if.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL if_unexpected: dut%0d delivered pc %h instr %h, expected nothing", k, ifpc[k], ifin[k]);
                end else begin
                    ef = exp_if.pop_front();
                    check("if_dut", 32'(k), {31'b0, ef[64]});
                    check("if_pc", ifpc[k], ef[63:32]);
                    check("if_instr", ifin[k], ef[31:0]);
                end
            end
            if (req_v[k] && req_rdy[k]) begin
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: dut%0d accepted addr %h, expected nothing", k, req_a[k]);
                end else begin
                    er = exp_req.pop_front();
                    check("req_dut", 32'(k), {31'b0, er[32]});
                    check("req_addr", req_a[k], er[31:0]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; redir_v[k] = 1'b0; redir_pc[k] = '0; req_rdy[k] = 1'b0;
            rsp_v[k] = 1'b0; rsp_d[k] = '0; if_rdy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        check("rst_if_valid", {31'b0, ifv[0]}, 32'd0);
        check("rst_req_valid", {31'b0, req_v[0]}, 32'd0);
        check("rst_if_pc", ifpc[0], 32'd0);
        check("rst_if_instr", ifin[0], 32'd0);

        // Reset release, first fetch and 2-cycle latency
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("t1_req_valid", {31'b0, req_v[0]}, 32'd1);
        check("t1_req_addr", req_a[0], 32'h0);
        push_req(0, 32'h0);
        cyc(0, 0, 1, 0, 1, 32'h13, 0, 0);
        check("t1_wait_no_req", {31'b0, req_v[0]}, 32'd0);
        push_if(0, 32'h0, 32'h13);

        // Decode stalled with buffer full
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0);
            check("t2_stall_if_valid", {31'b0, ifv[0]}, 32'd1);
            check("t2_stall_if_pc", ifpc[0], 32'h0);
            check("t2_stall_if_instr", ifin[0], 32'h13);
            check("t2_stall_no_req", {31'b0, req_v[0]}, 32'd0);
        end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        check("t2_drain_req_valid", {31'b0, req_v[0]}, 32'd1);
        check("t2_drain_req_addr", req_a[0], 32'h4);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        check("t2_req_addr", req_a[0], 32'h4);
        push_req(0, 32'h4);
        cyc(0, 0, 0, 1, 1, 32'h93, 0, 0);
        push_if(0, 32'h4, 32'h93);

        // Memory backpressure for 3 cycles
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 0, 0);
            check("t3_hold_valid", {31'b0, req_v[0]}, 32'd1);
            check("t3_hold_addr", req_a[0], 32'h8);
        end
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        check("t3_accept_addr", req_a[0], 32'h8);
        push_req(0, 32'h8);
        cyc(0, 0, 1, 1, 1, 32'h113, 0, 0);
        check("t3_wait_no_req", {31'b0, req_v[0]}, 32'd0);
        push_if(0, 32'h8, 32'h113);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        check("t3_next_addr", req_a[0], 32'hC);
        push_req(0, 32'hC);

        // Redirect in WAIT, response two cycles later is dropped
        cyc(0, 0, 0, 1, 0, 0, 1, 32'h103);
        check("t4_wait_no_req", {31'b0, req_v[0]}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        check("t4_drain_if_valid", {31'b0, ifv[0]}, 32'd0);
        check("t4_drain_no_req", {31'b0, req_v[0]}, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        check("t4_dropped_if_valid", {31'b0, ifv[0]}, 32'd0);
        check("t4_target_addr", req_a[0], 32'h100);
        push_req(0, 32'h100);

        // Redirect together with response, then redirect while request unaccepted
        cyc(0, 0, 0, 1, 1, 32'h55, 1, 32'h200);
        cyc(0, 0, 0, 1, 0, 0, 1, 32'h300);
        check("t5a_if_valid", {31'b0, ifv[0]}, 32'd0);
        check("t5a_req_addr", req_a[0], 32'h200);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        check("t5b_held_valid", {31'b0, req_v[0]}, 32'd1);
        check("t5b_held_addr", req_a[0], 32'h200);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        push_req(0, 32'h200);
        cyc(0, 0, 1, 1, 1, 32'hBAD, 0, 0);
        check("t5b_drain_no_req", {31'b0, req_v[0]}, 32'd0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        check("t5b_if_valid", {31'b0, ifv[0]}, 32'd0);
        check("t5b_target_addr", req_a[0], 32'h300);
        push_req(0, 32'h300);
        cyc(0, 0, 0, 1, 1, 32'h333, 0, 0);
        push_if(0, 32'h300, 32'h333);

        // Redirect voids a same-cycle decode handshake
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        push_req(0, 32'h304);
        cyc(0, 0, 0, 1, 1, 32'h444, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 1, 32'h400);
        check("t5c_pre_flush_valid", {31'b0, ifv[0]}, 32'd1);
        push_req(0, 32'h308);
        cyc(0, 0, 0, 1, 1, 32'h555, 0, 0);
        check("t5c_flushed", {31'b0, ifv[0]}, 32'd0);
        check("t5c_drain_no_req", {31'b0, req_v[0]}, 32'd0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        push_req(0, 32'h400);
        cyc(0, 0, 0, 1, 1, 32'h13, 0, 0);
        push_if(0, 32'h400, 32'h13);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);

        // RESET_PC = 0xFFFFFFFC: wrap, then reset mid-WAIT
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        check("t6_first_addr", req_a[1], 32'hFFFF_FFFC);
        push_req(1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 1, 1, 32'h6, 0, 0);
        push_if(1, 32'hFFFF_FFFC, 32'h6);
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        check("t6_wrap_addr", req_a[1], 32'h0);
        push_req(1, 32'h0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        check("t6_rst_req_valid", {31'b0, req_v[1]}, 32'd0);
        check("t6_rst_if_valid", {31'b0, ifv[1]}, 32'd0);
        cyc(1, 1, 0, 1, 1, 32'h77, 0, 0);
        check("t6_rst_if_pc", ifpc[1], 32'h0);
        check("t6_rst_if_instr", ifin[1], 32'h0);
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        check("t6_post_rst_addr", req_a[1], 32'hFFFF_FFFC);
        push_req(1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 1, 1, 32'h7, 0, 0);
        push_if(1, 32'hFFFF_FFFC, 32'h7);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);

        check("left_if_expect", exp_if.size(), 32'd0);
        check("left_req_expect", exp_req.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
